// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: default sizes and Gray/binary pointer conversion.
package fifo_pkg;

    localparam int DSIZE_DEF    = 8;
    localparam int ADDRSIZE_DEF = 8;
    localparam int PTR_W        = ADDRSIZE_DEF + 1;

    // Functions work on a 32-bit container; zero-extended Gray codes decode unchanged.
    localparam int CODE_W = 32;

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready skid buffer whose upstream ready is a flop, not a function of out_ready.
module fifo_skid_buf import fifo_pkg::*; #(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    output logic             s_ready,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    input  logic             out_ready
);

    logic             out_v, out_v_n;
    logic [DSIZE-1:0] out_d, out_d_n;
    logic             sk_v, sk_v_n;
    logic [DSIZE-1:0] sk_d, sk_d_n;
    logic             accept;
    logic             drain;

    assign accept    = s_valid & s_ready;
    assign drain     = out_v & out_ready;
    assign out_valid = out_v;
    assign out_data  = out_d;

    // The skid entry is always older than anything arriving now, so it refills the output first.
    always_comb begin
        out_v_n = out_v;
        out_d_n = out_d;
        sk_v_n  = sk_v;
        sk_d_n  = sk_d;
        if (drain) begin
            if (sk_v) begin
                out_d_n = sk_d;
                sk_v_n  = accept;
                sk_d_n  = s_data;
            end else if (accept) begin
                out_d_n = s_data;
            end else begin
                out_v_n = 1'b0;
            end
        end else if (accept) begin
            if (!out_v) begin
                out_v_n = 1'b1;
                out_d_n = s_data;
            end else begin
                sk_v_n  = 1'b1;
                sk_d_n  = s_data;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            out_v   <= 1'b0;
            out_d   <= '0;
            sk_v    <= 1'b0;
            sk_d    <= '0;
            s_ready <= 1'b0;
        end else begin
            out_v   <= out_v_n;
            out_d   <= out_d_n;
            sk_v    <= sk_v_n;
            sk_d    <= sk_d_n;
            s_ready <= ~sk_v_n;
        end
    end

endmodule

// File: rtl/fifo_wr_frontend.sv
// Write-side front end: skid-buffers the producer stream into the FIFO write port and
// reports a conservative fill level, almost-full flag and high-water mark.
module fifo_wr_frontend import fifo_pkg::*; #(
    parameter int DSIZE        = DSIZE_DEF,
    parameter int ADDRSIZE     = ADDRSIZE_DEF,
    parameter int AFULL_THRESH = (1 << ADDRSIZE) - 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    input  logic [DSIZE-1:0]    s_data,
    output logic                s_ready,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   hwm,
    input  logic                hwm_clr
);

    localparam int PTR_WIDTH = ADDRSIZE + 1;
    localparam logic [PTR_WIDTH-1:0] AFULL_LVL = PTR_WIDTH'(AFULL_THRESH);

    logic                 out_v;
    logic [DSIZE-1:0]     out_d;
    logic                 out_ready;
    logic [PTR_WIDTH-1:0] wbin_w;
    logic [PTR_WIDTH-1:0] wbin_r;
    logic [PTR_WIDTH-1:0] level_next;

    assign out_ready = ~wfull;

    fifo_skid_buf #(
        .DSIZE (DSIZE)
    ) u_skid (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .out_valid (out_v),
        .out_data  (out_d),
        .out_ready (out_ready)
    );

    assign winc  = out_v & ~wfull;
    assign wdata = out_d;

    // Modular subtraction absorbs pointer wrap; a stale read pointer can only inflate the level.
    assign wbin_w     = PTR_WIDTH'(gray2bin(CODE_W'(wptr)));
    assign wbin_r     = PTR_WIDTH'(gray2bin(CODE_W'(wq2_rptr)));
    assign level_next = wbin_w - wbin_r;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
            hwm          <= '0;
        end else begin
            wlevel       <= level_next;
            walmost_full <= (wlevel >= AFULL_LVL);
            if (hwm_clr) begin
                hwm <= '0;
            end else if (wlevel > hwm) begin
                hwm <= wlevel;
            end
        end
    end

endmodule

// File: doc/fifo_wr_frontend.md
Name: fifo_wr_frontend

Overview:
- Write-side front end of the async FIFO, sitting directly upstream of the write-pointer/full block in the wclk domain.
- Accepts a producer valid/ready stream and buffers it in a 2-entry skid buffer, so s_ready is registered and not combinationally dependent on wfull.
- Drives winc/wdata into the FIFO write port.
- Converts the Gray wptr and synchronized wq2_rptr to binary to report a conservative fill level, an almost-full flag and a high-water mark.

Parameters:
- DSIZE, 8, data width in bits.
- ADDRSIZE, 8, FIFO address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- AFULL_THRESH, 2^ADDRSIZE-4, level at or above which walmost_full asserts; legal range 1..2^ADDRSIZE.

Ports:
- wclk, input, 1, write-domain clock.
- wrst_n, input, 1, asynchronous active-low reset.
- s_valid, input, 1, producer data valid.
- s_data, input, DSIZE, producer data.
- s_ready, output, 1, registered ready to producer.
- winc, output, 1, write strobe to FIFO write port.
- wdata, output, DSIZE, write data to FIFO memory.
- wfull, input, 1, registered full flag from the write-pointer block.
- wptr, input, ADDRSIZE+1, Gray write pointer from the write-pointer block.
- wq2_rptr, input, ADDRSIZE+1, Gray read pointer synchronized into wclk.
- wlevel, output, ADDRSIZE+1, registered conservative fill level.
- walmost_full, output, 1, registered (wlevel >= AFULL_THRESH).
- hwm, output, ADDRSIZE+1, highest wlevel seen since reset or last clear.
- hwm_clr, input, 1, synchronous clear of hwm.

Behaviour:
- Reset (wrst_n low, async): s_ready=0, winc=0, wdata=0, wlevel=0, walmost_full=0, hwm=0, both skid entries invalid.
  - s_ready rises on the first wclk edge after reset deassertion.
  - Reset mid-transfer discards buffered data with no write issued.
- Skid buffer: output stage (out_v, out_d) plus skid stage (sk_v, sk_d).
  - Accept = s_valid & s_ready.
  - Drain = winc = out_v & ~wfull (combinational).
  - wdata = out_d at all times.
  - On accept with the output stage empty, or draining with no skid entry, data loads the output stage.
  - On accept while the output stage is held (not draining), data loads the skid stage.
  - On drain with a skid entry, the skid moves to the output stage in the same edge.
  - Simultaneous accept and drain with the skid empty: new data replaces the output stage; no bubble.
  - Next s_ready = ~(next sk_v). It therefore drops the cycle after the skid fills and rises the cycle after the skid drains.
- Ordering and loss: data order is preserved. Accepted data is never dropped or duplicated.
- Latency: accept at edge N with an empty buffer and wfull=0 gives winc=1 in cycle N..N+1, and the FIFO write occurs at edge N+1.
  - Sustained throughput is 1 word/cycle while wfull=0.
- wfull=1: winc is held 0. At most 2 further words are accepted; s_ready then drops. Writes resume the cycle wfull falls.
- Level:
  - wbin_w = gray2bin(wptr), wbin_r = gray2bin(wq2_rptr).
  - wlevel <= (wbin_w - wbin_r) mod 2^(ADDRSIZE+1), registered 1 cycle.
  - Pointer wrap is handled by the modular subtraction.
  - Stale wq2_rptr only over-reports the level; wlevel never under-reports.
  - Max reported value is 2^ADDRSIZE.
- walmost_full is registered from the new wlevel value, so it lags the pointers by 2 cycles.
- hwm:
  - If hwm_clr, hwm <= 0. Clear takes priority over an update in the same cycle.
  - Otherwise, if wlevel > hwm, hwm <= wlevel.
- gray2bin: bit i = XOR of Gray bits ADDRSIZE..i. Purely combinational, one instance per pointer.

Decomposition:
- Shared package fifo_pkg:
  - gray2bin/bin2gray functions.
  - Default DSIZE/ADDRSIZE constants.
  - PTR_W = ADDRSIZE+1.
- One sub-module: fifo_skid_buf (2-entry valid/ready skid, parameter DSIZE), instantiated once.
- Level/hwm logic stays inline in fifo_wr_frontend.

Test Plan (ADDRSIZE=4, DSIZE=8, AFULL_THRESH=12):
- Reset, then release → s_ready=0 during reset, 1 one edge after release; all other outputs 0.
- Stream 0x01..0x10 back-to-back with wfull=0 → winc=1 for 16 consecutive cycles; wdata sequence 0x01..0x10; s_ready stays 1.
- Force wfull=1 while streaming 0xA0.. → exactly 0xA0, 0xA1 accepted and s_ready=0; deassert wfull → 0xA0, 0xA1 written in order, then accepts resume with no loss.
- wptr=Gray(13)=0x0B, wq2_rptr=Gray(1)=0x01 → wlevel=12 after 1 cycle, walmost_full=1 one cycle later.
- Wrap: wptr=Gray(3), wq2_rptr=Gray(30) → wlevel=5, walmost_full=0.
- hwm reaches 12; pulse hwm_clr in the same cycle wlevel=14 → hwm=0, then 14 next cycle. Assert wrst_n low mid-stream → buffer empties, winc=0 immediately.
